// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver (device-clocked, host idle).
// Synchronises and de-glitches PS2_CLK, shifts in 11-bit frames on each
// filtered falling edge, folds 0xE0/0xF0 prefixes into flags and emits one
// KEY_VALID strobe per complete key event.
// Optional build macro: PS2_PARITY_CHECK_EN (enforce odd parity at STOP).
//
// Output handshake: KEY_VALID and FRAME_ERR are single-cycle strobes with no
// back-pressure; KEY_CODE/KEY_EXT/KEY_BREAK are valid in the KEY_VALID cycle
// and hold until the next KEY_VALID.
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_BREAK,
  output logic       KEY_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHK = 1'b1;
`else
  localparam bit PARITY_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   s_clk, s_data;
  logic                   clk_filt;
  logic [FW-1:0]          flt_cnt;
  logic                   sample;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   timeout;
  logic                   ext_pending, brk_pending;
  logic                   parity_ok;
  logic                   key_evt, err_evt, set_ext, set_brk;

  assign s_clk  = clk_sync[SYNC_STAGES-1];
  assign s_data = data_sync[SYNC_STAGES-1];

  // Filtered falling edge: the sample that flips clk_filt from 1 to 0.
  assign sample  = clk_filt && !s_clk && (flt_cnt == FW'(FILTER_LEN - 1));
  assign timeout = (state != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  // Parity bit is always latched; it only gates decoding when checking is built in.
  assign parity_ok = !PARITY_CHK || (^{shift_reg, par_bit});
  assign BUSY = (state != IDLE);

  // Pin synchronisers, preset to the idle-high line level.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
    end
  end

  // Clock de-glitch: follow s_clk only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (s_clk == clk_filt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= s_clk;
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_next;
  end

  // Next-state logic and frame evaluation; a timeout overrides everything but a sample.
  always_comb begin
    state_next = state;
    key_evt    = 1'b0;
    err_evt    = 1'b0;
    set_ext    = 1'b0;
    set_brk    = 1'b0;
    case (state)
      IDLE:   if (sample && !s_data) state_next = DATA;
      DATA:   if (sample && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (sample) state_next = STOP;
      STOP: begin
        if (sample) begin
          state_next = IDLE;
          if (!s_data || !parity_ok) err_evt = 1'b1;
          else if (shift_reg == 8'hE0) set_ext = 1'b1;
          else if (shift_reg == 8'hF0) set_brk = 1'b1;
          else key_evt = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout) begin
      state_next = IDLE;
      err_evt    = 1'b1;
    end
  end

  // Frame datapath: bit counter, shift register, parity latch, inter-edge timer.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (state == IDLE || sample) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      if (sample) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shift_reg <= {s_data, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= s_data;
          default: ;
        endcase
      end
    end
  end

  // Prefix flags and registered key outputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      KEY_CODE    <= '0;
      KEY_EXT     <= 1'b0;
      KEY_BREAK   <= 1'b0;
      KEY_VALID   <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      KEY_VALID <= key_evt;
      FRAME_ERR <= err_evt;
      if (key_evt) begin
        KEY_CODE  <= shift_reg;
        KEY_EXT   <= ext_pending;
        KEY_BREAK <= brk_pending;
      end
      if (key_evt || err_evt) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else begin
        if (set_ext) ext_pending <= 1'b1;
        if (set_brk) brk_pending <= 1'b1;
      end
    end
  end

endmodule
